// File: rtl/axis_traffic_gen.sv
// AXI-Stream synthetic traffic generator: LFSR-gated packet injection with
// selectable destination patterns, per-destination and total packet counters.
module axis_traffic_gen #(
  parameter int          TDATA_WIDTH = 64,
  parameter int          TDEST_WIDTH = 4,
  parameter int          TID_WIDTH   = 2,
  parameter int          NUM_ROUTERS = 10,
  parameter int          TID         = 0,
  parameter int          COUNT_WIDTH = 32,
  parameter logic [31:0] SEED        = 32'd1,
  parameter int          MAX_PKT_LEN = 8,
  localparam int         LEN_W       = $clog2(MAX_PKT_LEN + 1),
  localparam int         HALF_W      = TDATA_WIDTH / 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [15:0]            load,
  input  logic [COUNT_WIDTH-1:0] num_packets,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [TDEST_WIDTH-1:0] fixed_dest,
  input  logic [LEN_W-1:0]       pkt_len,
  input  logic [HALF_W-1:0]      ticks,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] sent_packets [NUM_ROUTERS],
  output logic [COUNT_WIDTH-1:0] total_sent_packets,
  output logic                   axis_out_tvalid,
  input  logic                   axis_out_tready,
  output logic [TDATA_WIDTH-1:0] axis_out_tdata,
  output logic                   axis_out_tlast,
  output logic [TID_WIDTH-1:0]   axis_out_tid,
  output logic [TDEST_WIDTH-1:0] axis_out_tdest
);

  localparam logic [31:0]            LFSR_INIT = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [31:0]            LFSR_TAPS = 32'h8020_0003;
  localparam logic [TDEST_WIDTH-1:0] LAST_DEST = TDEST_WIDTH'(NUM_ROUTERS - 1);
  localparam logic [LEN_W-1:0]       MAX_LEN   = LEN_W'(MAX_PKT_LEN);

  typedef enum logic [1:0] {S_IDLE, S_GAP, S_SEND, S_DONE} state_t;

  state_t                 r_state, w_state_next;
  logic [31:0]            r_lfsr;
  logic [TDEST_WIDTH-1:0] r_rr;
  logic [TDEST_WIDTH-1:0] r_dest;
  logic [LEN_W-1:0]       r_len;
  logic [LEN_W-1:0]       r_flit;
  logic [HALF_W-1:0]      r_ts;
  logic [COUNT_WIDTH-1:0] r_cnt [NUM_ROUTERS];
  logic [COUNT_WIDTH-1:0] r_total;

  logic [31:0]            w_lfsr_next;
  logic                   w_inject;
  logic                   w_take;
  logic                   w_fire;
  logic                   w_last;
  logic [TDEST_WIDTH-1:0] w_rand_dest;
  logic [TDEST_WIDTH-1:0] w_rr_next;
  logic [TDEST_WIDTH-1:0] w_dest;
  logic [LEN_W-1:0]       w_len;
  logic [COUNT_WIDTH-1:0] w_cnt_sel;
  logic [COUNT_WIDTH-1:0] w_total_inc;
  logic [HALF_W-1:0]      w_lo;

  assign w_lfsr_next = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? LFSR_TAPS : '0);
  assign w_inject    = (load == 16'hFFFF) || (r_lfsr[15:0] < load);
  assign w_total_inc = r_total + 1'b1;

  // Scale the upper LFSR half into [0, NUM_ROUTERS) without a divider.
  assign w_rand_dest = TDEST_WIDTH'((32'(r_lfsr[31:16]) * 32'(NUM_ROUTERS)) >> 16);
  assign w_rr_next   = (r_rr == LAST_DEST) ? '0 : r_rr + 1'b1;

  always_comb begin
    w_dest = w_rand_dest;
    unique case (mode)
      2'd0: w_dest = w_rand_dest;
      2'd1: w_dest = (32'(fixed_dest) >= 32'(NUM_ROUTERS)) ? LAST_DEST : fixed_dest;
      2'd2: w_dest = r_rr;
      2'd3: begin
        if (32'(w_rand_dest) == 32'(TID))
          w_dest = (w_rand_dest == LAST_DEST) ? '0 : w_rand_dest + 1'b1;
      end
      default: w_dest = w_rand_dest;
    endcase
  end

  always_comb begin
    w_len = pkt_len;
    if (pkt_len == '0)         w_len = LEN_W'(1);
    else if (pkt_len > MAX_LEN) w_len = MAX_LEN;
  end

  always_comb begin
    w_cnt_sel = '0;
    for (int unsigned j = 0; j < NUM_ROUTERS; j++)
      if (r_dest == TDEST_WIDTH'(j)) w_cnt_sel = r_cnt[j];
  end

  assign w_lo = (r_flit == '0) ? HALF_W'(w_cnt_sel) : HALF_W'(r_flit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next    = r_state;
    w_take          = 1'b0;
    done            = 1'b0;
    axis_out_tvalid = 1'b0;
    axis_out_tlast  = 1'b0;
    axis_out_tdata  = '0;
    axis_out_tdest  = '0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          if (r_total == num_packets)     w_state_next = S_DONE;
          else if (r_total < num_packets) w_state_next = S_GAP;
        end
      end
      S_GAP: begin
        if (!start) begin
          w_state_next = S_IDLE;
        end else if (w_inject) begin
          w_take       = 1'b1;
          w_state_next = S_SEND;
        end
      end
      S_SEND: begin
        axis_out_tvalid = 1'b1;
        axis_out_tlast  = (r_flit == r_len - 1'b1);
        axis_out_tdata  = {r_ts, w_lo};
        axis_out_tdest  = r_dest;
        if (axis_out_tready && axis_out_tlast)
          w_state_next = (w_total_inc == num_packets) ? S_DONE : S_GAP;
      end
      S_DONE: done = 1'b1;
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_fire = axis_out_tvalid && axis_out_tready;
  assign w_last = w_fire && axis_out_tlast;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr  <= LFSR_INIT;
      r_rr    <= '0;
      r_dest  <= '0;
      r_len   <= '0;
      r_flit  <= '0;
      r_ts    <= '0;
      r_total <= '0;
      for (int unsigned j = 0; j < NUM_ROUTERS; j++) r_cnt[j] <= '0;
    end else begin
      if (r_state == S_GAP) r_lfsr <= w_lfsr_next;
      if (w_take) begin
        r_dest <= w_dest;
        r_len  <= w_len;
        r_ts   <= ticks;
        r_flit <= '0;
        if (mode == 2'd2) r_rr <= w_rr_next;
      end
      if (w_last) begin
        r_total <= w_total_inc;
        for (int unsigned j = 0; j < NUM_ROUTERS; j++)
          if (r_dest == TDEST_WIDTH'(j)) r_cnt[j] <= r_cnt[j] + 1'b1;
      end else if (w_fire) begin
        r_flit <= r_flit + 1'b1;
      end
    end
  end

  assign sent_packets       = r_cnt;
  assign total_sent_packets = r_total;
  assign axis_out_tid       = TID_WIDTH'(TID);

endmodule
